mod_mul: RTL

Sequential 256-bit modular multiplier over the secp256k1 field prime, computing product = operand_a × operand_b mod p by MSB-first interleaved double-and-add, one multiplier bit per clock. It is the forward-direction counterpart to mod_inv: it checks inverses (x × inverse mod p == 1, flagged on is_one) and provides field multiplication for the point-arithmetic datapath. It uses the same start/done handshake as mod_inv, so one controller can sequence both blocks.

---
 rtl/mod_mul.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/mod_mul.sv
// ============================================================================
// Module   : mod_mul
// Purpose  : Sequential 256-bit modular multiplier over the secp256k1 prime.
//            It uses MSB-first double-and-add and handles one multiplier bit
//            per clock.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mod_mul #(
    parameter int               WIDTH   = 256,
    parameter logic [WIDTH-1:0] MODULUS =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic [WIDTH-1:0] product,
    output logic             is_one,
    output logic             done,
    output logic             busy
);

    localparam int                 c_cnt_w   = $clog2(WIDTH);
    localparam logic [1:0]         c_st_idle = 2'd0;
    localparam logic [1:0]         c_st_load = 2'd1;
    localparam logic [1:0]         c_st_run  = 2'd2;
    localparam logic [1:0]         c_st_done = 2'd3;
    localparam logic [WIDTH:0]     c_mod_ext = {1'b0, MODULUS};
    localparam logic [c_cnt_w-1:0] c_cnt_top = c_cnt_w'(WIDTH - 1);

    logic [1:0]         state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [c_cnt_w-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]   product_q, product_d;
    logic               is_one_q, is_one_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;

    logic [WIDTH:0]     w_dbl;
    logic [WIDTH-1:0]   w_dbl_red;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_sum_red;
    logic [WIDTH-1:0]   w_acc_next;

    // Both reduced values are < p < 2^WIDTH, so the subtraction is done modulo
    // 2^WIDTH on the low bits. The carry bit is still used in the compare.
    assign w_dbl      = {acc_q, 1'b0};
    assign w_dbl_red  = (w_dbl >= c_mod_ext) ? (w_dbl[WIDTH-1:0] - MODULUS)
                                             : w_dbl[WIDTH-1:0];
    assign w_sum      = {1'b0, w_dbl_red} + {1'b0, a_q};
    assign w_sum_red  = (w_sum >= c_mod_ext) ? (w_sum[WIDTH-1:0] - MODULUS)
                                             : w_sum[WIDTH-1:0];
    assign w_acc_next = b_q[cnt_q] ? w_sum_red : w_dbl_red;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= c_st_idle;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            is_one_q  <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            is_one_q  <= is_one_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_st_idle: if (start) state_d = c_st_load;
            c_st_load: state_d = c_st_run;
            c_st_run:  if (cnt_q == '0) state_d = c_st_done;
            c_st_done: state_d = c_st_idle;
            default:   state_d = c_st_idle;
        endcase
    end

    always_comb begin
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        is_one_d  = is_one_q;
        done_d    = 1'b0;
        busy_d    = busy_q;
        case (state_q)
            c_st_idle: begin
                if (start) begin
                    a_d    = operand_a;
                    b_d    = operand_b;
                    busy_d = 1'b1;
                end
            end
            c_st_load: begin
                // A single subtraction suffices because p > 2^(WIDTH-1).
                a_d   = (a_q >= MODULUS) ? (a_q - MODULUS) : a_q;
                acc_d = '0;
                cnt_d = c_cnt_top;
            end
            c_st_run: begin
                acc_d = w_acc_next;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    product_d = w_acc_next;
                    is_one_d  = (w_acc_next == WIDTH'(1));
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                end
            end
            default: begin
            end
        endcase
    end

    assign product = product_q;
    assign is_one  = is_one_q;
    assign done    = done_q;
    assign busy    = busy_q;

endmodule

`default_nettype wire
